// File: rtl/leve_ifetch_buf_if.sv
// Handshake bundle for the LEVE instruction fetch buffer: PC request, AXI4 read
// address/data channels and the decode-side instruction stream.
interface leve_ifetch_buf_if #(
  parameter int XLEN = 64
);
  logic            PC_VALID;
  logic            PC_READY;
  logic [XLEN-1:0] PC_PC;
  logic            FLUSH;

  logic            ARVALID;
  logic            ARREADY;
  logic [31:0]     ARADDR;
  logic [1:0]      ARBURST;
  logic [7:0]      ARLEN;

  logic            RVALID;
  logic            RREADY;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;

  logic            INST_VALID;
  logic            INST_READY;
  logic [31:0]     INST_DATA;
  logic [XLEN-1:0] INST_PC;
  logic            INST_ERR;

  modport master (
    input  PC_VALID, PC_PC, FLUSH, ARREADY, RVALID, RDATA, RRESP, RLAST, INST_READY,
    output PC_READY, ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
           INST_VALID, INST_DATA, INST_PC, INST_ERR
  );

  modport slave (
    output PC_VALID, PC_PC, FLUSH, ARREADY, RVALID, RDATA, RRESP, RLAST, INST_READY,
    input  PC_READY, ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
           INST_VALID, INST_DATA, INST_PC, INST_ERR
  );
endinterface

// File: rtl/leve_ifetch_buf.sv
// Instruction fetch buffer: one AXI4 WRAP burst per accepted PC, beats queued
// with their own PC and error tag in a FIFO that drains to decode.
//
// state | meaning
// IDLE  | waiting for a PC; accepts only when a whole burst fits in the FIFO
// ADDR  | ARVALID held high until ARREADY
// DATA  | beats pushed into the FIFO until RLAST
// DRAIN | beats of a flushed burst accepted and dropped until RLAST
module leve_ifetch_buf #(
  parameter int XLEN      = 64,
  parameter int BURST_LEN = 4,
  parameter int DEPTH     = 8
) (
  input logic CLK,
  input logic RST,
  leve_ifetch_buf_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(BURST_LEN);
  localparam int WB = IW + 2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [IW-1:0]   idx;
  logic            flush_pend;
  logic            arvalid_q;
  logic            rready_q;

  logic [CW-1:0]   count;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [31:0]     mem_data [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic            mem_err  [DEPTH];

  logic [CW-1:0]   free;
  logic            pc_ready;
  logic            inst_valid;
  logic            push;
  logic            pop;
  logic [WB-1:0]   beat_lo;
  logic [XLEN-1:0] beat_pc;

  assign free       = CW'(DEPTH) - count;
  assign pc_ready   = (state == IDLE) && (free >= CW'(BURST_LEN)) && !bus.FLUSH && !RST;
  assign inst_valid = (count != '0);
  assign push       = (state == DATA) && bus.RVALID && !bus.FLUSH;
  assign pop        = inst_valid && bus.INST_READY && !bus.FLUSH;

  // Wrap within the BURST_LEN*4 byte window; bits above the window pass through.
  assign beat_lo = pc_q[WB-1:0] + {idx, 2'b00};
  assign beat_pc = {pc_q[XLEN-1:WB], beat_lo};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      pc_q       <= '0;
      idx        <= '0;
      flush_pend <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      count      <= '0;
      wp         <= '0;
      rp         <= '0;
    end else begin
      if (bus.FLUSH) begin
        count <= '0;
        wp    <= '0;
        rp    <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end

      case (state)
        IDLE: begin
          if (bus.PC_VALID && pc_ready) begin
            pc_q       <= bus.PC_PC & ~XLEN'(3);
            idx        <= '0;
            flush_pend <= 1'b0;
            arvalid_q  <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (bus.FLUSH) flush_pend <= 1'b1;
          if (bus.ARREADY) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            flush_pend <= 1'b0;
            state      <= (flush_pend || bus.FLUSH) ? DRAIN : DATA;
          end
        end
        DATA: begin
          if (push) idx <= idx + 1'b1;
          if (bus.RVALID && bus.RLAST) begin
            rready_q <= 1'b0;
            state    <= IDLE;
          end else if (bus.FLUSH) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.RVALID && bus.RLAST) begin
            rready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wp] <= bus.RDATA;
      mem_pc[wp]   <= beat_pc;
      mem_err[wp]  <= (bus.RRESP != 2'b00);
    end
  end

  assign bus.PC_READY   = pc_ready;
  assign bus.ARVALID    = arvalid_q;
  assign bus.ARADDR     = pc_q[31:0];
  assign bus.ARBURST    = 2'b10;
  assign bus.ARLEN      = 8'(BURST_LEN - 1);
  assign bus.RREADY     = rready_q;
  assign bus.INST_VALID = inst_valid;
  assign bus.INST_DATA  = inst_valid ? mem_data[rp] : '0;
  assign bus.INST_PC    = inst_valid ? mem_pc[rp]   : '0;
  assign bus.INST_ERR   = inst_valid ? mem_err[rp]  : 1'b0;
endmodule
